matrix2hash_packer: RTL and testbench

- Parametrised successor to the matrix-out → SHA3 input framer.
- Accepts a stream of 64-bit matrix result words, buffers them, and emits frames to the sha3_out input FIFO.
- Each frame is one header word followed by N_WORDS data words, with an optional trailer word.
- Unlike the previous generation, it honours fifo_full backpressure, exposes input-side ready, supports configurable frame length and header, and flags dropped input words.

---
 rtl/m2h_pkg.sv | 20 ++
 rtl/m2h_in_fifo.sv | 59 +++++
 rtl/matrix2hash_packer.sv | 125 ++++++++++++
 tb/tb_matrix2hash_packer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/m2h_pkg.sv
// m2h_pkg: shared types and constants for the matrix-to-SHA3 frame packer.
//   m2h_state_e         : framer FSM states (S_TRAILER exists only when the
//                         M2H_TRAILER_EN macro is defined)
//   M2H_DEFAULT_HEADER  : default header word opening every frame
//   M2H_DEFAULT_TRAILER : default trailer word closing a frame (trailer builds)
package m2h_pkg;

  localparam logic [63:0] M2H_DEFAULT_HEADER  = 64'h8000000000000100;
  localparam logic [63:0] M2H_DEFAULT_TRAILER = 64'h0000000000000080;

  typedef enum logic [1:0] {
    S_HEADER  = 2'd0,
    S_DATA    = 2'd1
`ifdef M2H_TRAILER_EN
    ,
    S_TRAILER = 2'd2
`endif
  } m2h_state_e;

endpackage

// File: rtl/m2h_in_fifo.sv
// m2h_in_fifo: synchronous input buffer for the frame packer.
// The head word is presented combinationally so the framer can write it in the
// same cycle it decides to pop.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (pointers only)
//   push, wdata   : write request and data (ignored when full)
//   pop           : remove head word (ignored when empty)
//   full, empty   : derived from the registered occupancy count
//   head          : word at the read pointer
module m2h_in_fifo #(
  parameter int DATA_W   = 64,
  parameter int IN_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(IN_DEPTH);

  logic [DATA_W-1:0] mem_q [IN_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == (AW+1)'(IN_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/matrix2hash_packer.sv
// matrix2hash_packer: frames a stream of matrix result words for the SHA3
// input FIFO. Each frame is HEADER_WORD followed by N_WORDS data words, plus
// TRAILER_WORD when built with the M2H_TRAILER_EN macro defined.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   we_in, din : input word; accepted when din_ready=1, dropped otherwise
//   din_ready  : input buffer not full (from registered occupancy)
//   fifo_full  : downstream backpressure; no write while high
//   we_out     : downstream write strobe; dout is zero whenever it is low
//   dout       : downstream write data
//   frame_done : pulses with the write of the final word of a frame
//   overflow   : sticky, set by any dropped input word, cleared by rst
module matrix2hash_packer
  import m2h_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                N_WORDS     = 4,
  parameter int                IN_DEPTH    = 8,
  parameter logic [DATA_W-1:0] HEADER_WORD = DATA_W'(M2H_DEFAULT_HEADER)
`ifdef M2H_TRAILER_EN
  ,
  parameter logic [DATA_W-1:0] TRAILER_WORD = DATA_W'(M2H_DEFAULT_TRAILER)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_in,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  input  logic              fifo_full,
  output logic              we_out,
  output logic [DATA_W-1:0] dout,
  output logic              frame_done,
  output logic              overflow
);

  localparam int              CNT_W = $clog2(N_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  m2h_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic              buf_full, buf_empty, pop;
  logic [DATA_W-1:0] buf_head;

  m2h_in_fifo #(
    .DATA_W  (DATA_W),
    .IN_DEPTH(IN_DEPTH)
  ) u_in_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (we_in),
    .wdata(din),
    .pop  (pop),
    .full (buf_full),
    .empty(buf_empty),
    .head (buf_head)
  );

  // A word offered while full is lost; the buffer itself ignores it.
  assign din_ready  = !buf_full;
  assign overflow_d = overflow_q | (we_in & buf_full);
  assign overflow   = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HEADER;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_out     = 1'b0;
    dout       = '0;
    frame_done = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_HEADER: begin
        // Wait for data before opening a frame.
        if (!buf_empty && !fifo_full) begin
          we_out  = 1'b1;
          dout    = HEADER_WORD;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!buf_empty && !fifo_full) begin
          we_out = 1'b1;
          dout   = buf_head;
          pop    = 1'b1;
          if (cnt_q == LAST) begin
`ifdef M2H_TRAILER_EN
            state_d = S_TRAILER;
`else
            frame_done = 1'b1;
            state_d    = S_HEADER;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef M2H_TRAILER_EN
      S_TRAILER: begin
        if (!fifo_full) begin
          we_out     = 1'b1;
          dout       = TRAILER_WORD;
          frame_done = 1'b1;
          state_d    = S_HEADER;
        end
      end
`endif
      default: state_d = S_HEADER;
    endcase
  end

endmodule

// File: tb/tb_matrix2hash_packer.sv
module tb_matrix2hash_packer;

  localparam int          N_WORDS = 4;
  localparam logic [63:0] HDR     = 64'h8000000000000100;
  localparam logic [63:0] TRL     = 64'h0000000000000080;
`ifdef M2H_TRAILER_EN
  localparam bit TRAILER_EN = 1'b1;
`else
  localparam bit TRAILER_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic        fd;
    logic        consec;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_in;
  logic [63:0] din;
  logic        din_ready;
  logic        fifo_full;
  logic        we_out;
  logic [63:0] dout;
  logic        frame_done;
  logic        overflow;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tb_pos   = 0;
  int   cyc      = 0;
  int   last_wr  = -10;

  always #5 clk = ~clk;

  matrix2hash_packer #(
    .DATA_W     (64),
    .N_WORDS    (N_WORDS),
    .IN_DEPTH   (8),
    .HEADER_WORD(HDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we_in     (we_in),
    .din       (din),
    .din_ready (din_ready),
    .fifo_full (fifo_full),
    .we_out    (we_out),
    .dout      (dout),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic fd, input logic consec);
    exp_t e;
    e.data = d; e.fd = fd; e.consec = consec;
    exp_q.push_back(e);
  endtask

  // Drive one input word for one cycle; predicted frame output is queued
  // only for words the buffer is expected to accept.
  task automatic push_word(input logic [63:0] w, input bit exp_acc,
                           input bit hdr_consec, input bit word_consec);
    bit last;
    chk("din_ready", din_ready, exp_acc);
    we_in = 1'b1;
    din   = w;
    if (exp_acc) begin
      last = (tb_pos == N_WORDS - 1);
      if (tb_pos == 0) push_exp(HDR, 1'b0, hdr_consec);
      push_exp(w, last && !TRAILER_EN, word_consec);
      if (last && TRAILER_EN) push_exp(TRL, 1'b1, 1'b1);
      tb_pos = last ? 0 : tb_pos + 1;
    end
    $display("in  w=%h accept=%0b", w, exp_acc);
    @(posedge clk); #1;
    we_in = 1'b0;
    din   = '0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    we_in     = 1'b0;
    din       = '0;
    fifo_full = 1'b0;

    // Scoreboard monitor: one check per written word, idle checks otherwise.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (we_out) begin
          $display("out cyc=%0d dout=%h fd=%0b", cyc, dout, frame_done);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write got=%h want=none", dout);
          end else begin
            e = exp_q.pop_front();
            chk("dout", dout, e.data);
            chk("frame_done", frame_done, e.fd);
            if (e.consec) chk("gap", 64'(cyc - last_wr), 64'd1);
          end
          last_wr = cyc;
        end else begin
          chk("idle_dout", dout, 64'd0);
          chk("idle_frame_done", frame_done, 64'd0);
        end
      end
    join_none

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_out", we_out, 0);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    idle(2);
    chk("post_rst_din_ready", din_ready, 1);
    chk("post_rst_overflow", overflow, 0);

    // Single frame, streamed one word per cycle.
    push_word(64'hA1, 1, 0, 1);
    push_word(64'hA2, 1, 0, 1);
    push_word(64'hA3, 1, 0, 1);
    push_word(64'hA4, 1, 0, 1);
    drain("t1_drain");
    chk("t1_overflow", overflow, 0);
    idle(3);

    // Two frames back to back: second header directly follows C4.
    push_word(64'hC1, 1, 0, 1);
    for (int i = 2; i <= 8; i++) push_word(64'(32'hC0 + i), 1, 1, 1);
    drain("t2_drain");
    idle(3);

    // Downstream stall for three cycles after D2 is written.
    fork
      begin
        push_word(64'hD1, 1, 0, 1);
        push_word(64'hD2, 1, 0, 1);
        push_word(64'hD3, 1, 0, 0);
        push_word(64'hD4, 1, 0, 1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 fifo_full = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("stall_we_out", we_out, 0);
          @(posedge clk);
        end
        #1 fifo_full = 1'b0;
      end
    join
    drain("t3_drain");
    idle(3);

    // Overflow: ten pushes into an 8-deep buffer with downstream full.
    fifo_full = 1'b1;
    for (int i = 1; i <= 10; i++)
      push_word(64'(32'hE0 + i), (i <= 8), (i == 5), (i != 1));
    chk("t4_din_ready_full", din_ready, 0);
    chk("t4_overflow", overflow, 1);
    fifo_full = 1'b0;
    drain("t4_drain");
    chk("t4_overflow_sticky", overflow, 1);
    idle(3);

    // Reset mid-frame after F2 is written.
    push_word(64'hF1, 1, 0, 1);
    push_word(64'hF2, 1, 0, 1);
    push_word(64'hF3, 1, 0, 1);
    push_word(64'hF4, 1, 0, 1);
    rst = 1'b1;
    exp_q.delete();
    tb_pos = 0;
    #1;
    chk("t5_rst_we_out", we_out, 0);
    chk("t5_rst_din_ready", din_ready, 1);
    chk("t5_rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    push_word(64'hB1, 1, 0, 1);
    push_word(64'hB2, 1, 0, 1);
    push_word(64'hB3, 1, 0, 1);
    push_word(64'hB4, 1, 0, 1);
    drain("t5_drain");
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
